// File: rtl/vc_fifo_pkg.sv
// Shared defaults for the virtual-channel FIFO bank and the VC index width helper.
package vc_fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 6;
  localparam int unsigned DEF_ADDR_WIDTH = 4;
  localparam int unsigned DEF_NUM_VC     = 2;

  // A single-VC bank still carries a 1-bit index so the ports never collapse to zero width.
  function automatic int unsigned vc_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vc_fifo_channel.sv
// One virtual-channel queue: storage, pointers, occupancy, status flags and sticky error.
// Watermark thresholds are ports only when VC_FIFO_WATERMARK_EN is defined.
module vc_fifo_channel
  import vc_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_req,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_req,
`ifdef VC_FIFO_WATERMARK_EN
  input  logic [ADDR_WIDTH:0]   af_thresh,
  input  logic [ADDR_WIDTH:0]   ae_thresh,
`endif
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_accept,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  wr_accept;
  logic                  overflow;
  logic                  underflow;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

`ifdef VC_FIFO_WATERMARK_EN
  assign almost_full  = (count >= af_thresh);
  assign almost_empty = (count <= ae_thresh);
`else
  assign almost_full  = (count == {1'b0, {ADDR_WIDTH{1'b1}}});
  assign almost_empty = (count == CNT_ONE);
`endif

  // A full queue still takes a write when the same cycle pops an entry; empty never falls through.
  assign rd_accept = rd_req && !empty;
  assign wr_accept = wr_req && (!full || rd_accept);
  assign overflow  = wr_req && !wr_accept;
  assign underflow = rd_req && empty;
  assign rd_data   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      error  <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      end
      if (wr_accept && !rd_accept) begin
        count <= count + CNT_ONE;
      end else if (rd_accept && !wr_accept) begin
        count <= count - CNT_ONE;
      end
      if (overflow || underflow) begin
        error <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/vc_fifo_bank.sv
// NUM_VC independent FIFOs sharing one write and one read port, steered by VC index.
// Optional watermark thresholds: define VC_FIFO_WATERMARK_EN.
module vc_fifo_bank
  import vc_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned NUM_VC     = DEF_NUM_VC,
  parameter int unsigned VC_W       = vc_width(NUM_VC)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_enable,
  input  logic [VC_W-1:0]       wr_vc,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_enable,
  input  logic [VC_W-1:0]       rd_vc,
`ifdef VC_FIFO_WATERMARK_EN
  input  logic [ADDR_WIDTH:0]   af_thresh,
  input  logic [ADDR_WIDTH:0]   ae_thresh,
`endif
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic [VC_W-1:0]       rd_vc_out,
  output logic [NUM_VC-1:0]     full,
  output logic [NUM_VC-1:0]     empty,
  output logic [NUM_VC-1:0]     almost_full,
  output logic [NUM_VC-1:0]     almost_empty,
  output logic [NUM_VC-1:0]     error
);

  logic [NUM_VC-1:0]     wr_sel;
  logic [NUM_VC-1:0]     rd_sel;
  logic [NUM_VC-1:0]     rd_acc;
  logic [DATA_WIDTH-1:0] ch_data [NUM_VC];
  logic [DATA_WIDTH-1:0] rd_mux;
  logic                  rd_any;

  // Indices at or beyond NUM_VC match no channel, so such requests vanish without touching flags.
  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    assign wr_sel[v] = wr_enable && (wr_vc == VC_W'(v));
    assign rd_sel[v] = rd_enable && (rd_vc == VC_W'(v));

    vc_fifo_channel #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_channel (
      .clk          (clk),
      .reset        (reset),
      .wr_req       (wr_sel[v]),
      .data_in      (data_in),
      .rd_req       (rd_sel[v]),
`ifdef VC_FIFO_WATERMARK_EN
      .af_thresh    (af_thresh),
      .ae_thresh    (ae_thresh),
`endif
      .rd_data      (ch_data[v]),
      .rd_accept    (rd_acc[v]),
      .full         (full[v]),
      .empty        (empty[v]),
      .almost_full  (almost_full[v]),
      .almost_empty (almost_empty[v]),
      .error        (error[v])
    );
  end

  assign rd_any = |rd_acc;

  always_comb begin
    rd_mux = '0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      rd_mux = rd_mux | (rd_acc[v] ? ch_data[v] : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      data_out  <= '0;
      rd_valid  <= 1'b0;
      rd_vc_out <= '0;
    end else begin
      rd_valid  <= rd_any;
      data_out  <= rd_any ? rd_mux : '0;
      rd_vc_out <= rd_any ? rd_vc : '0;
    end
  end

endmodule

// File: tb/tb_vc_fifo_bank.sv
// Scoreboard bench for vc_fifo_bank: stimulus queues expected read data, a monitor checks it.
module tb_vc_fifo_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_enable;
  logic       wr_vc;
  logic [5:0] data_in;
  logic       rd_enable;
  logic       rd_vc;
  logic [5:0] data_out;
  logic       rd_valid;
  logic       rd_vc_out;
  logic [1:0] full;
  logic [1:0] empty;
  logic [1:0] almost_full;
  logic [1:0] almost_empty;
  logic [1:0] error;
`ifdef VC_FIFO_WATERMARK_EN
  logic [4:0] af_thresh;
  logic [4:0] ae_thresh;
`endif

  typedef struct {
    logic [5:0] data;
    logic       vc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   done = 1'b0;

  always #5 clk = ~clk;

  vc_fifo_bank #(
    .DATA_WIDTH (6),
    .ADDR_WIDTH (4),
    .NUM_VC     (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_enable    (wr_enable),
    .wr_vc        (wr_vc),
    .data_in      (data_in),
    .rd_enable    (rd_enable),
    .rd_vc        (rd_vc),
`ifdef VC_FIFO_WATERMARK_EN
    .af_thresh    (af_thresh),
    .ae_thresh    (ae_thresh),
`endif
    .data_out     (data_out),
    .rd_valid     (rd_valid),
    .rd_vc_out    (rd_vc_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .error        (error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock with the given request; inputs return to idle afterwards.
  task automatic cyc(input logic we, input logic wv, input logic [5:0] wd,
                     input logic re, input logic rv);
    wr_enable = we;
    wr_vc     = wv;
    data_in   = wd;
    rd_enable = re;
    rd_vc     = rv;
    @(posedge clk);
    #1;
    wr_enable = 1'b0;
    rd_enable = 1'b0;
  endtask

  task automatic expect_rd(input logic [5:0] d, input logic vc);
    exp_t e;
    e.data = d;
    e.vc   = vc;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    reset = 1'b1;
  endtask

  // Monitor: every cycle, a valid read must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (done) break;
      if (rd_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_rd: got data %0h vc %0h with nothing expected at %0t",
                   data_out, rd_vc_out, $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rd_data", 32'(data_out), 32'(e.data));
          check("rd_vc_out", 32'(rd_vc_out), 32'(e.vc));
        end
      end else if (reset === 1'b1) begin
        check("idle_data_zero", 32'(data_out), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wr_enable = 1'b0;
    rd_enable = 1'b0;
    wr_vc     = 1'b0;
    rd_vc     = 1'b0;
    data_in   = '0;
    reset     = 1'b1;
`ifdef VC_FIFO_WATERMARK_EN
    af_thresh = 5'd12;
    ae_thresh = 5'd3;
`endif

    do_reset();
    check("rst_empty", 32'(empty), 32'h3);
    check("rst_full", 32'(full), 32'h0);
    check("rst_error", 32'(error), 32'h0);
    check("rst_rd_valid", 32'(rd_valid), 32'h0);
    check("rst_data_out", 32'(data_out), 32'h0);

`ifndef VC_FIFO_WATERMARK_EN
    // Fill VC0 with 1..16, watching the flags at each occupancy.
    for (int k = 1; k <= 16; k++) begin
      cyc(1'b1, 1'b0, 6'(k), 1'b0, 1'b0);
      check("fill_full0", 32'(full[0]), 32'(k == 16));
      check("fill_af0", 32'(almost_full[0]), 32'(k == 15));
      check("fill_ae0", 32'(almost_empty[0]), 32'(k == 1));
    end
    check("fill_empty1", 32'(empty[1]), 32'h1);
    check("fill_error", 32'(error), 32'h0);

    // Full VC0: read and write together; both go through, no error.
    expect_rd(6'd1, 1'b0);
    cyc(1'b1, 1'b0, 6'h3F, 1'b1, 1'b0);
    check("rw_full0", 32'(full[0]), 32'h1);
    check("rw_error", 32'(error), 32'h0);

    // Overflow: dropped write flags VC0 only, and the flag persists.
    cyc(1'b1, 1'b0, 6'h2A, 1'b0, 1'b0);
    check("ovf_error", 32'(error), 32'h1);
    check("ovf_full0", 32'(full[0]), 32'h1);
    cyc(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    check("ovf_sticky", 32'(error), 32'h1);

    // Back-to-back drain: 2..16 then 0x3F as the 16th read; 0x2A never appears.
    for (int k = 2; k <= 16; k++) expect_rd(6'(k), 1'b0);
    expect_rd(6'h3F, 1'b0);
    rd_enable = 1'b1;
    rd_vc     = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      #1;
    end
    rd_enable = 1'b0;
    check("drain_empty0", 32'(empty[0]), 32'h1);
    cyc(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);

    // Underflow on VC1 after a clean reset.
    do_reset();
    check("rst2_error", 32'(error), 32'h0);
    cyc(1'b0, 1'b0, 6'd0, 1'b1, 1'b1);
    check("udf_rd_valid", 32'(rd_valid), 32'h0);
    check("udf_data_out", 32'(data_out), 32'h0);
    check("udf_error", 32'(error), 32'h2);

    // Interleaved VCs.
    cyc(1'b1, 1'b0, 6'd5, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 6'd9, 1'b0, 1'b0);
    expect_rd(6'd9, 1'b1);
    cyc(1'b0, 1'b0, 6'd0, 1'b1, 1'b1);
    expect_rd(6'd5, 1'b0);
    cyc(1'b0, 1'b0, 6'd0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    check("intlv_empty", 32'(empty), 32'h3);

    // 40 write/read pairs on VC0 wrap the pointers more than twice.
    for (int k = 1; k <= 40; k++) begin
      cyc(1'b1, 1'b0, 6'(k), 1'b0, 1'b0);
      expect_rd(6'(k), 1'b0);
      cyc(1'b0, 1'b0, 6'd0, 1'b1, 1'b0);
    end
    cyc(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    check("wrap_empty0", 32'(empty[0]), 32'h1);

    // Reset with a read in flight: queued data is discarded, no rd_valid follows.
    cyc(1'b1, 1'b1, 6'd7, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 6'd8, 1'b0, 1'b0);
    reset = 1'b0;
    cyc(1'b0, 1'b0, 6'd0, 1'b1, 1'b1);
    reset = 1'b1;
    check("midrst_rd_valid", 32'(rd_valid), 32'h0);
    check("midrst_empty", 32'(empty), 32'h3);
    check("midrst_error", 32'(error), 32'h0);
    cyc(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
`else
    // Watermarks at af=12, ae=3 on VC0.
    check("wm_ae_at0", 32'(almost_empty[0]), 32'h1);
    check("wm_af_at0", 32'(almost_full[0]), 32'h0);
    for (int k = 1; k <= 13; k++) begin
      cyc(1'b1, 1'b0, 6'(k + 20), 1'b0, 1'b0);
      check("wm_af0", 32'(almost_full[0]), 32'(k >= 12));
      check("wm_ae0", 32'(almost_empty[0]), 32'(k <= 3));
    end
    check("wm_ae1", 32'(almost_empty[1]), 32'h1);
    for (int k = 1; k <= 13; k++) begin
      expect_rd(6'(k + 20), 1'b0);
      cyc(1'b0, 1'b0, 6'd0, 1'b1, 1'b0);
    end
    cyc(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    check("wm_empty0", 32'(empty[0]), 32'h1);
    check("wm_error", 32'(error), 32'h0);
`endif

    cyc(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vc_fifo_bank.md
# vc_fifo_bank

Multi-channel virtual-channel FIFO bank for the PCIe transmit path, generalising the single-VC FIFO to `NUM_VC` independent queues. The queues share one write port and one read port, each steered by a VC index. Overflow and underflow are blocked rather than corrupting state, and each VC records them in a sticky error flag. It sits between the transaction-layer packet source and the VC arbiter, which consumes the per-VC status flags.

## Interface
- `DATA_WIDTH`, 6, payload width per entry
- `ADDR_WIDTH`, 4, log2 of per-VC depth; `DEPTH` = 2**`ADDR_WIDTH`
- `NUM_VC`, 2, number of virtual channels (≥1)
- `VC_W`, `$clog2(NUM_VC)` (min 1), VC index width
- `clk` in 1: clock, rising edge
- `reset` in 1: synchronous, active-low
- `wr_enable` in 1: write request
- `wr_vc` in `VC_W`: target VC for write
- `data_in` in `DATA_WIDTH`: write data
- `rd_enable` in 1: read request
- `rd_vc` in `VC_W`: source VC for read
- `af_thresh` in `ADDR_WIDTH`+1: almost-full level (only with the macro enabled)
- `ae_thresh` in `ADDR_WIDTH`+1: almost-empty level (only with the macro enabled)
- `data_out` out `DATA_WIDTH`: registered read data; 0 when `rd_valid`=0
- `rd_valid` out 1: `data_out` holds a popped entry
- `rd_vc_out` out `VC_W`: VC that `data_out` came from
- `full` out `NUM_VC`: per VC, count == `DEPTH`
- `empty` out `NUM_VC`: per VC, count == 0
- `almost_full` out `NUM_VC`: per VC almost-full flag
- `almost_empty` out `NUM_VC`: per VC almost-empty flag
- `error` out `NUM_VC`: per VC sticky overflow/underflow flag

## Operation
- Each VC has its own memory of `DEPTH` entries, plus `wr_ptr`/`rd_ptr` (`ADDR_WIDTH` bits, natural wrap) and a count (`ADDR_WIDTH`+1 bits, range 0..`DEPTH`).
- **Write acceptance:** `wr_enable` && (!`full[wr_vc]` || read accepted on the same VC this cycle).
  - On acceptance: store at `wr_ptr`, then increment `wr_ptr`.
- **Read acceptance:** `rd_enable` && !`empty[rd_vc]`.
  - A same-cycle write to an empty VC does not satisfy the read (no fall-through).
- **Count update per VC:**
  - +1 on a write only
  - −1 on a read only
  - unchanged on both, or on neither
  - Count never leaves 0..`DEPTH`.
- **Rejected write** (VC full, no same-VC read): data dropped, pointers and count unchanged, `error[wr_vc]` set.
- **Rejected read** (VC empty): `error[rd_vc]` set; next cycle `rd_valid`=0 and `data_out`=0.
- `error` bits stay set until reset.
- Out-of-range `wr_vc`/`rd_vc` (≥`NUM_VC`): request ignored, no flag changes.
- **Status flags** are combinational from the registered counts.
- **Reset** (`reset`=0 at a clock edge): all pointers and counts = 0, `data_out`=0, `rd_valid`=0, `rd_vc_out`=0, `error`=0. Memory contents are not cleared.
  - Reset mid-operation discards all queued data; any in-flight read produces no `rd_valid`.
  - Reset-state flags: `empty`=all 1, `full`=0.

## Timing
- Read latency: 1 cycle. A read accepted at edge N gives `data_out`/`rd_valid`/`rd_vc_out` valid after edge N, held for one cycle. `rd_valid` drops the following cycle unless another read is accepted.
- Writes become visible in the count and flags after the writing edge and are readable from the next cycle.
- Back-to-back reads on any VC sustain one entry per cycle.
- Full-VC write plus same-VC read in one cycle: both accepted; count stays `DEPTH`.

## Configuration
- `VC_FIFO_WATERMARK_EN` defined:
  - `af_thresh`/`ae_thresh` ports exist.
  - `almost_full[v]` = count ≥ `af_thresh`; `almost_empty[v]` = count ≤ `ae_thresh`.
  - Thresholds are shared by all VCs and sampled combinationally.
- Not defined:
  - Ports absent.
  - `almost_full[v]` = count == `DEPTH`−1; `almost_empty[v]` = count == 1.

## Structure
- Package `vc_fifo_pkg` holds the default widths and depth constants, plus a function giving `VC_W` from `NUM_VC`.
- Sub-module `vc_fifo_channel` is one queue: memory, pointers, count, flags, and accept logic given a same-VC read.
  - Instantiated `NUM_VC` times via generate.
  - The top level decodes the VC indices, muxes `data_out` and registers the read outputs.

## Test plan
- **Reset then fill:** reset, write VC0 values 1..16 → `full[0]`=1, `almost_full[0]` asserted at count 15, `empty[1]`=1, `error`=0.
- **Overflow:** write 0x2A to full VC0 → count stays 16; `error[0]`=1 next cycle and persists; later reads return 1..16 in order.
- **Underflow:** read empty VC1 → `rd_valid`=0, `data_out`=0, `error[1]`=1, `error[0]` unaffected.
- **Simultaneous full read+write:** VC0 full, read VC0 and write 0x3F in the same cycle → `data_out`=1, count 16, no error; 0x3F emerges as the 16th subsequent read.
- **Interleaved VCs and wrap:** write VC0 5, VC1 9, then read VC1, VC0 → `data_out` 9 (`rd_vc_out`=1) then 5 (`rd_vc_out`=0). Also 40 write/read pairs on VC0 (pointer wrap) return data in order.
- **Watermarks** (macro defined): `af_thresh`=12, `ae_thresh`=3 → `almost_full[0]` rises at count 12, `almost_empty[0]` is 1 at counts 0..3.
